upsp_ac_wdata_serializer: RTL and testbench



---
 rtl/upsp_ac_wdata_serializer.sv | 143 ++++++++++++++
 tb/tb_upsp_ac_wdata_serializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/upsp_ac_wdata_serializer.sv
// rtl/upsp_ac_wdata_serializer.sv - 4-pixel word FIFO and one-pixel-per-beat serializer with raster markers
`timescale 1ns/1ps
module upsp_ac_wdata_serializer #(
    parameter int BUFFER_WIDTH = 24,
    parameter int OUT_WIDTH    = 1920,
    parameter int OUT_HEIGHT   = 1080,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BUFFER_WIDTH*4-1:0] upsp_ac_wdata,
    input  logic                      upsp_ac_wvalid,
    output logic                      ac_upsp_wready,
    output logic [BUFFER_WIDTH-1:0]   m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      frame_done
);

    localparam int WW = BUFFER_WIDTH * 4;
    localparam int CW = $clog2(OUT_WIDTH);
    localparam int RW = $clog2(OUT_HEIGHT);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] COL_LAST = CW'(OUT_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_HEIGHT - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);

    logic [WW-1:0]           r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [PW:0]             r_count;
    logic [1:0]              r_sub;
    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_row;
    logic                    r_frame_done;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_xfer;
    logic                    w_pop;
    logic                    w_col_last;
    logic                    w_row_last;
    logic [WW-1:0]           w_head;
    logic [BUFFER_WIDTH-1:0] w_pixel;

    // Ready and valid come only from the registered occupancy, so neither
    // side sees a combinational path from the other's handshake.
    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push     = upsp_ac_wvalid & !w_full;
    assign w_xfer     = !w_empty & m_axis_tready;
    assign w_pop      = w_xfer & (r_sub == 2'd3);
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_head     = r_mem[r_rd_ptr];

    assign ac_upsp_wready = !w_full;
    assign m_axis_tvalid  = !w_empty;
    assign m_axis_tdata   = w_pixel;
    assign m_axis_tlast   = !w_empty & w_col_last;
    assign m_axis_tuser   = !w_empty & (r_col == '0) & (r_row == '0);
    assign frame_done     = r_frame_done;

    // Pick the current pixel out of the head word; forced to zero when empty
    // so a drained FIFO never shows a stale pixel.
    always_comb begin
        w_pixel = '0;
        if (!w_empty) begin
            case (r_sub)
                2'd0:    w_pixel = w_head[0*BUFFER_WIDTH +: BUFFER_WIDTH];
                2'd1:    w_pixel = w_head[1*BUFFER_WIDTH +: BUFFER_WIDTH];
                2'd2:    w_pixel = w_head[2*BUFFER_WIDTH +: BUFFER_WIDTH];
                default: w_pixel = w_head[3*BUFFER_WIDTH +: BUFFER_WIDTH];
            endcase
        end
    end

    // Word storage; contents need no reset because the pointers and count
    // define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= upsp_ac_wdata;
        end
    end

    // FIFO pointers and occupancy; a push and pop in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sub-word index and raster position advance once per transferred pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub <= 2'd0;
            r_col <= '0;
            r_row <= '0;
        end else if (w_xfer) begin
            r_sub <= r_sub + 2'd1;
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // One-cycle pulse following the transfer of the frame's final pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_xfer & w_col_last & w_row_last;
        end
    end

endmodule

// File: tb/tb_upsp_ac_wdata_serializer.sv
// tb/tb_upsp_ac_wdata_serializer.sv - self-checking bench for upsp_ac_wdata_serializer
`timescale 1ns/1ps
module tb_upsp_ac_wdata_serializer;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int FP = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] upsp_ac_wdata;
    logic        upsp_ac_wvalid;
    logic        ac_upsp_wready;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        frame_done;

    always #5 clk = ~clk;

    upsp_ac_wdata_serializer #(
        .BUFFER_WIDTH (24),
        .OUT_WIDTH    (W),
        .OUT_HEIGHT   (H),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .upsp_ac_wdata  (upsp_ac_wdata),
        .upsp_ac_wvalid (upsp_ac_wvalid),
        .ac_upsp_wready (ac_upsp_wready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .frame_done     (frame_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending pixels in order, pixels transferred since
    // reset, and whether a frame_done pulse is due this cycle.
    logic [23:0] q [$];
    int          pix_n   = 0;
    logic        fd_exp  = 1'b0;
    int          fd_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int words();
        return (q.size() + 3) / 4;
    endfunction

    function automatic logic [95:0] rnd_word();
        logic [95:0] v;
        v = {$urandom(), $urandom(), $urandom()};
        return v;
    endfunction

    // Called at a falling edge: drive inputs, check outputs against the model,
    // then advance the model by the handshakes that the next rising edge takes.
    task automatic cycle(input logic wv, input logic [95:0] wd, input logic tr, output logic acc);
        logic push;
        logic xfer;
        upsp_ac_wvalid = wv;
        upsp_ac_wdata  = wd;
        m_axis_tready  = tr;
        #1;
        check("wready", 32'(ac_upsp_wready), 32'(words() < 4));
        check("tvalid", 32'(m_axis_tvalid), 32'(q.size() > 0));
        check("tdata", 32'(m_axis_tdata), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        check("tlast", 32'(m_axis_tlast), 32'(q.size() > 0 && (pix_n % W) == W - 1));
        check("tuser", 32'(m_axis_tuser), 32'(q.size() > 0 && (pix_n % FP) == 0));
        check("frame_done", 32'(frame_done), 32'(fd_exp));
        if (frame_done === 1'b1) fd_seen++;
        push   = wv && (words() < 4);
        xfer   = tr && (q.size() > 0);
        fd_exp = 1'b0;
        if (xfer) begin
            fd_exp = ((pix_n % FP) == FP - 1);
            void'(q.pop_front());
            pix_n++;
        end
        if (push) begin
            for (int k = 0; k < 4; k++) q.push_back(wd[k*24 +: 24]);
        end
        acc = push;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        upsp_ac_wvalid = 1'b0;
        upsp_ac_wdata  = '0;
        m_axis_tready  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst    = 1'b0;
        q.delete();
        pix_n  = 0;
        fd_exp = 1'b0;
    endtask

    initial begin
        logic        acc;
        int          n;
        int          pushed;
        logic [95:0] w0;

        @(negedge clk);

        // Reset then idle
        do_reset();
        #1;
        check("rst_wready", 32'(ac_upsp_wready), 32'd1);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        repeat (3) cycle(1'b0, '0, 1'b1, acc);

        // Single word, pixels 1..4 on consecutive beats
        cycle(1'b1, 96'h000004_000003_000002_000001, 1'b1, acc);
        check("t2_px0", 32'(m_axis_tdata), 32'd1);
        repeat (5) cycle(1'b0, '0, 1'b1, acc);

        // Backpressure fill: four words accepted, then stall
        n = 0;
        w0 = rnd_word();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, (i == 0) ? w0 : rnd_word(), 1'b0, acc);
            if (acc) n++;
        end
        check("t3_accepted", 32'(n), 32'd4);
        check("t3_wready", 32'(ac_upsp_wready), 32'd0);
        check("t3_head", 32'(m_axis_tdata), 32'(w0[23:0]));
        repeat (18) cycle(1'b0, '0, 1'b1, acc);

        // Line/frame markers on an 8x2 frame
        do_reset();
        fd_seen = 0;
        for (int i = 0; i < 4; i++) begin
            w0 = rnd_word();
            n  = 0;
            do begin
                cycle(1'b1, w0, 1'b1, acc);
                n++;
            end while (!acc && n < 20);
            check("t4_push_timeout", 32'(acc), 32'd1);
        end
        n = 0;
        while ((q.size() > 0 || fd_exp) && n < 50) begin
            cycle(1'b0, '0, 1'b1, acc);
            n++;
        end
        check("t4_drain_timeout", 32'(n < 50), 32'd1);
        check("t4_frames", 32'(fd_seen), 32'd1);
        cycle(1'b1, rnd_word(), 1'b0, acc);
        check("t4_next_tuser", 32'(m_axis_tuser), 32'd1);
        repeat (5) cycle(1'b0, '0, 1'b1, acc);

        // Random handshakes over three frames
        do_reset();
        fd_seen = 0;
        pushed  = 0;
        n       = 0;
        while (!(pix_n == 3 * FP && !fd_exp) && n < 3000) begin
            cycle((pushed < 3 * FP / 4) && ($urandom() % 2 == 1), rnd_word(),
                  ($urandom() % 2 == 1), acc);
            if (acc) pushed++;
            n++;
        end
        check("t5_timeout", 32'(n < 3000), 32'd1);
        check("t5_frames", 32'(fd_seen), 32'd3);
        check("t5_drained", 32'(m_axis_tvalid), 32'd0);

        // Mid-frame reset with two words buffered
        do_reset();
        repeat (3) cycle(1'b1, rnd_word(), 1'b0, acc);
        repeat (6) cycle(1'b0, '0, 1'b1, acc);
        check("t6_buffered", 32'(words()), 32'd2);
        do_reset();
        #1;
        check("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t6_wready", 32'(ac_upsp_wready), 32'd1);
        @(negedge clk);
        cycle(1'b1, rnd_word(), 1'b0, acc);
        check("t6_tuser", 32'(m_axis_tuser), 32'd1);
        repeat (6) cycle(1'b0, '0, 1'b1, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
